// File: rtl/cell_sweep_sequencer.sv
// cell_sweep_sequencer: walks all 64 cell input vectors over a page range and folds cell_out into a 16-bit MISR.
// Ports: clk, rst (async, active-high); start/abort control; page_first/page_last range (sampled at start);
//   cell_out response in; page/cell_in drive the cell mux; busy/done/err status; signature = MISR value.
// Build option: define CELL_SWEEP_GRAY_EN to drive cell_in in Gray order instead of binary.
module cell_sweep_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter logic [15:0] SIG_POLY = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  page_first,
  input  logic [4:0]  page_last,
  input  logic [7:0]  cell_out,
  output logic [4:0]  page,
  output logic [5:0]  cell_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] signature
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0] idx, idx_n, code;
  logic [4:0] last, last_n, page_n;
  logic [15:0] sig_n;
  logic busy_n, done_n, err_n, bad;
`ifdef CELL_SWEEP_GRAY_EN
  assign code = idx_n ^ (idx_n >> 1);
`else
  assign code = idx_n;
`endif
  assign bad = page_first > page_last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    page_n = page;
    last_n = last;
    sig_n = signature;
    busy_n = busy;
    done_n = done;
    err_n = err;
    if (abort) begin
      state_n = IDLE;
      busy_n = 1'b0;
      done_n = 1'b0;
      err_n = 1'b0;
    end else if (start && (state == IDLE || state == DONE)) begin
      state_n = bad ? DONE : APPLY;
      cnt_n = '0;
      idx_n = '0;
      page_n = page_first;
      last_n = page_last;
      sig_n = '0;
      busy_n = !bad;
      done_n = bad;
      err_n = bad;
    end else if (state == APPLY) begin
      state_n = (cnt == CW'(SETTLE_CYCLES - 1)) ? SAMPLE : APPLY;
      cnt_n = (cnt == CW'(SETTLE_CYCLES - 1)) ? '0 : cnt + 1'b1;
    end else if (state == SAMPLE) begin
      sig_n = {signature[14:0], 1'b0} ^ (signature[15] ? SIG_POLY : 16'h0) ^ {8'h00, cell_out};
      idx_n = idx + 1'b1;
      page_n = (idx == 6'd63 && page < last) ? page + 1'b1 : page;
      state_n = (idx == 6'd63 && page >= last) ? DONE : APPLY;
      busy_n = !(idx == 6'd63 && page >= last);
      done_n = idx == 6'd63 && page >= last;
      // the final vector leaves idx at 63 so cell_in stays on the last vector
      idx_n = (idx == 6'd63 && page >= last) ? idx : idx_n;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      last <= '0;
      page <= '0;
      cell_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      signature <= '0;
    end else begin
      cnt <= cnt_n;
      idx <= idx_n;
      last <= last_n;
      page <= page_n;
      cell_in <= code;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
      signature <= sig_n;
    end
endmodule

// File: tb/tb_cell_sweep_sequencer.sv
// tb_cell_sweep_sequencer: directed self-checking bench for cell_sweep_sequencer.
module tb_cell_sweep_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [4:0] page_first = '0, page_last = '0, page;
  logic [7:0] cell_out = '0;
  logic [5:0] cell_in;
  logic busy, done, err;
  logic [15:0] signature;
  int n_cmp = 0, n_bad = 0;
  cell_sweep_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .page_first(page_first), .page_last(page_last), .cell_out(cell_out),
    .page(page), .cell_in(cell_in), .busy(busy), .done(done), .err(err),
    .signature(signature)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] code(input int k);
    logic [5:0] v;
    v = 6'(k);
`ifdef CELL_SWEEP_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [4:0] f, input logic [4:0] l);
    page_first = f;
    page_last = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int c;
    logic saw_zero;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_page", page, 0);
    chk("rst_cell_in", cell_in, 0);
    chk("rst_sig", signature, 0);
    rst = 1'b0;
    cyc(1);
    go(5'd3, 5'd3);
    chk("t1_busy0", busy, 1);
    chk("t1_page0", page, 3);
    for (c = 0; c < 192; c++) begin
      chk("t1_cell_in", cell_in, code(c / 3));
      if (c != 191) cyc(1);
    end
    chk("t1_busy_end", busy, 1);
    cyc(1);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_err", err, 0);
    chk("t1_sig", signature, 16'h0000);
    chk("t1_page", page, 3);
    cell_out = 8'hA5;
    go(5'd3, 5'd3);
    chk("t2_done_clr", done, 0);
    chk("t2_sig0", signature, 0);
    cyc(3);
    cell_out = 8'h00;
    chk("t2_sig_s0", signature, 16'h00A5);
    cyc(3);
    chk("t2_sig_s1", signature, 16'h014A);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sig_hold", signature, 16'h014A);
    cyc(2);
    chk("abort_idle_sig", signature, 16'h014A);
    go(5'd30, 5'd31);
    saw_zero = 1'b0;
    c = 0;
    while (!done && c < 500) begin
      if (page == 0) saw_zero = 1'b1;
      if (c == 191) chk("t3_page30", page, 30);
      if (c == 192) chk("t3_page31", page, 31);
      cyc(1);
      c++;
    end
    chk("t3_latency", c, 384);
    chk("t3_no_wrap", saw_zero, 0);
    chk("t3_page_end", page, 31);
    chk("t3_done", done, 1);
    go(5'd5, 5'd4);
    chk("t4_done", done, 1);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_sig", signature, 0);
    go(5'd7, 5'd7);
    chk("t4_err_clr", err, 0);
    chk("t4_restart_busy", busy, 1);
    cyc(30);
    chk("t5_vec10", cell_in, code(10));
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_cell_hold", cell_in, code(10));
    chk("t5_page_hold", page, 7);
    cell_out = 8'h3C;
    go(5'd9, 5'd9);
    chk("t5_re_page", page, 9);
    chk("t5_re_cell", cell_in, 0);
    chk("t5_re_sig", signature, 0);
    cyc(3);
    cell_out = 8'h00;
    chk("t5_re_sig1", signature, 16'h003C);
    go(5'd12, 5'd12);
    chk("t6_ign_page", page, 9);
    chk("t6_ign_cell", cell_in, code(1));
    chk("t6_ign_sig", signature, 16'h003C);
    abort = 1'b1;
    start = 1'b1;
    cyc(1);
    abort = 1'b0;
    start = 1'b0;
    chk("t6_abort_wins", busy, 0);
    go(5'd2, 5'd4);
    cyc(7);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_page", page, 0);
    chk("t6_rst_cell", cell_in, 0);
    chk("t6_rst_sig", signature, 0);
    chk("t6_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    chk("t6_idle_after_rst", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
